imm_extend_ctrl: RTL

Decode-stage controller for immediate extension.
- Accepts I-type opcode plus 16-bit immediate over valid/ready, selects the extension mode (sign, zero, upper, branch-offset), and produces the 32-bit operand.
- A 2-entry skid buffer decouples decode from the ID/EX register so stalls never drop or duplicate immediates.
- Sits between the instruction decoder and the ALU-B / branch-target muxes.

---
 rtl/imm_extend_pkg.sv | 28 ++
 rtl/imm_extend_unit.sv | 47 ++++
 rtl/imm_extend_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/imm_extend_pkg.sv
// Shared constants for the decode-stage immediate extender: widths, I-type opcodes, mode codes.
// Optional feature macro used by the controller: IMM_EXT_ILLEGAL_CNT_EN.
package imm_extend_pkg;

  localparam int WORD_LEN        = 32;
  localparam int IMM_LEN         = 16;
  localparam int OPC_LEN         = 6;
  localparam int SIGN_EXTEND_LEN = WORD_LEN - IMM_LEN;

  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [1:0] MODE_NONE  = 2'd0;
  localparam logic [1:0] MODE_SIGN  = 2'd1;
  localparam logic [1:0] MODE_ZERO  = 2'd2;
  localparam logic [1:0] MODE_UPPER = 2'd3;

endpackage

// File: rtl/imm_extend_unit.sv
// Combinational opcode decode and immediate extension (sign, zero, upper, branch offset).
module imm_extend_unit #(
  parameter int WORD_LEN = 32,
  parameter int IMM_LEN  = 16,
  parameter int OPC_LEN  = 6
) (
  input  logic [OPC_LEN-1:0]  opcode,
  input  logic [IMM_LEN-1:0]  imm,
  output logic [WORD_LEN-1:0] result,
  output logic [1:0]          mode,
  output logic                is_branch
);
  import imm_extend_pkg::*;

  localparam int EXT_LEN = WORD_LEN - IMM_LEN;

  logic [WORD_LEN-1:0] sext;
  assign sext = {{EXT_LEN{imm[IMM_LEN-1]}}, imm};

  always_comb begin
    result    = '0;
    mode      = MODE_NONE;
    is_branch = 1'b0;
    case (6'(opcode))
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU, OPC_LW, OPC_SW: begin
        mode   = MODE_SIGN;
        result = sext;
      end
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        mode   = MODE_ZERO;
        result = {{EXT_LEN{1'b0}}, imm};
      end
      OPC_LUI: begin
        mode   = MODE_UPPER;
        result = {imm, {EXT_LEN{1'b0}}};
      end
      // Branch offsets are word-aligned: reported as SIGN with the branch flag.
      OPC_BEQ, OPC_BNE: begin
        mode      = MODE_SIGN;
        is_branch = 1'b1;
        result    = {sext[WORD_LEN-3:0], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_extend_ctrl.sv
// Immediate-extension controller: extends at accept, then holds results in a 2-entry skid buffer.
// Optional macro IMM_EXT_ILLEGAL_CNT_EN adds a saturating count of accepted NONE-mode opcodes.
module imm_extend_ctrl #(
  parameter int WORD_LEN = 32,
  parameter int IMM_LEN  = 16,
  parameter int OPC_LEN  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                inValid,
  output logic                inReady,
  input  logic [OPC_LEN-1:0]  inOpcode,
  input  logic [IMM_LEN-1:0]  inImm,
  output logic                outValid,
  input  logic                outReady,
  output logic [WORD_LEN-1:0] outImm,
  output logic [1:0]          outMode,
  output logic                outIsBranch
`ifdef IMM_EXT_ILLEGAL_CNT_EN
  ,
  output logic [15:0]         illegalCnt
`endif
);
  import imm_extend_pkg::*;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t              state;
  logic [WORD_LEN-1:0] ext_result, tail_imm;
  logic [1:0]          ext_mode, tail_mode;
  logic                ext_branch, tail_branch;
  logic                accept, drain;

  imm_extend_unit #(
    .WORD_LEN (WORD_LEN),
    .IMM_LEN  (IMM_LEN),
    .OPC_LEN  (OPC_LEN)
  ) u_ext (
    .opcode    (inOpcode),
    .imm       (inImm),
    .result    (ext_result),
    .mode      (ext_mode),
    .is_branch (ext_branch)
  );

  assign accept = inValid && inReady;
  assign drain  = outValid && outReady;

  // Head entry drives the outputs directly; tail only fills while the head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_EMPTY;
      outValid    <= 1'b0;
      inReady     <= 1'b1;
      outImm      <= '0;
      outMode     <= MODE_NONE;
      outIsBranch <= 1'b0;
      tail_imm    <= '0;
      tail_mode   <= MODE_NONE;
      tail_branch <= 1'b0;
    end else if (flush) begin
      state    <= S_EMPTY;
      outValid <= 1'b0;
      inReady  <= 1'b1;
    end else begin
      case (state)
        S_EMPTY: if (accept) begin
          outImm      <= ext_result;
          outMode     <= ext_mode;
          outIsBranch <= ext_branch;
          state       <= S_ONE;
          outValid    <= 1'b1;
        end
        S_ONE: begin
          if (accept && drain) begin
            outImm      <= ext_result;
            outMode     <= ext_mode;
            outIsBranch <= ext_branch;
          end else if (accept) begin
            tail_imm    <= ext_result;
            tail_mode   <= ext_mode;
            tail_branch <= ext_branch;
            state       <= S_FULL;
            inReady     <= 1'b0;
          end else if (drain) begin
            state    <= S_EMPTY;
            outValid <= 1'b0;
          end
        end
        S_FULL: if (drain) begin
          outImm      <= tail_imm;
          outMode     <= tail_mode;
          outIsBranch <= tail_branch;
          state       <= S_ONE;
          inReady     <= 1'b1;
        end
        default: begin
          state    <= S_EMPTY;
          outValid <= 1'b0;
          inReady  <= 1'b1;
        end
      endcase
    end
  end

`ifdef IMM_EXT_ILLEGAL_CNT_EN
  // Counts every NONE-mode handshake on the input side, independent of flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegalCnt <= '0;
    else if (accept && ext_mode == MODE_NONE && illegalCnt != 16'hFFFF)
      illegalCnt <= illegalCnt + 16'd1;
  end
`endif

endmodule
